mc_control_fsm: RTL and testbench

- Multi-cycle main controller for the MIPS32 datapath (fetch, decode, execute with ALU/ALU_Control/branch adder, memory, writeback).
- Decodes the opcode from the instruction register and steps the shared ALU, memory port and register file through one instruction at a time.
- Issues per-cycle mux selects and write enables, and stalls on a memory ready handshake.
- Sits beside the datapath; its only inputs are opcode, zero_flag and mem_ready.

---
 rtl/mc_control_fsm.sv | 216 +++++++++++++++++++++
 tb/tb_mc_control_fsm.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS32 main controller.
// Steps the shared ALU, memory port and register file through one
// instruction at a time, stalling on mem_ready in the memory states and
// aborting a memory wait after MEM_WAIT_MAX idle cycles.
//
// Handshake: mem_ready is a level "memory done" qualifier, sampled only in
// FETCH, MEMRD and MEMWR. The controller holds its strobes until the cycle
// mem_ready=1 is seen, then advances on that clock edge. In all other
// states mem_ready is ignored.
module mc_control_fsm #(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero_flag,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic [3:0] state,
  output logic       illegal_op,
  output logic       mem_timeout
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_ALUWB  = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_JUMP   = 4'd9;
  localparam logic [3:0] S_ADDIEX = 4'd10;
  localparam logic [3:0] S_ADDIWB = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [7:0] WAIT_MAX = 8'(MEM_WAIT_MAX);

  logic [3:0] state_q;
  logic [3:0] state_d;
  logic [7:0] wait_cnt;
  logic       illegal_hit;
  logic       illegal_q;
  logic       timeout_q;
  logic       wait_state;
  logic       timeout_hit;

  // zero_flag only matters to the datapath (pc_write_cond is ANDed there).
  logic unused_zero;
  assign unused_zero = zero_flag;

  assign wait_state  = (state_q == S_FETCH) || (state_q == S_MEMRD) ||
                       (state_q == S_MEMWR);
  // mem_ready=1 in the limit cycle wins over the abort.
  assign timeout_hit = wait_state && !mem_ready && (wait_cnt == WAIT_MAX);

  assign state       = state_q;
  assign illegal_op  = illegal_q;
  assign mem_timeout = timeout_q;

  // State register, wait counter and registered pulse outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      wait_cnt  <= 8'd0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_hit;
      timeout_q <= timeout_hit;
      // Counter restarts on any state change (entry) and on abort.
      if (state_d != state_q || timeout_hit)
        wait_cnt <= 8'd0;
      else if (wait_state && !mem_ready)
        wait_cnt <= wait_cnt + 8'd1;
      else
        wait_cnt <= 8'd0;
    end
  end

  // Next-state selection from opcode and memory handshake.
  always_comb begin
    state_d     = state_q;
    illegal_hit = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (mem_ready)        state_d = S_DECODE;
        else if (timeout_hit) state_d = S_FETCH;
      end
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     state_d = S_EXEC;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDIEX;
          default: begin
            state_d     = S_FETCH;
            illegal_hit = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        if (opcode == OP_LW)      state_d = S_MEMRD;
        else if (opcode == OP_SW) state_d = S_MEMWR;
        else                      state_d = S_FETCH;
      end
      S_MEMRD: begin
        if (mem_ready)        state_d = S_MEMWB;
        else if (timeout_hit) state_d = S_FETCH;
      end
      S_MEMWR: begin
        if (mem_ready || timeout_hit) state_d = S_FETCH;
      end
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP, S_ADDIWB: state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // Per-state datapath controls; strobes are forced low while in reset.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: alu_src_b = 2'b11;
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        mem_write = !timeout_hit;
        i_or_d    = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_ADDIWB: reg_write = 1'b1;
      default: ;
    endcase
    if (!rst_n) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: instruction-level stimulus generator builds the
// expected per-cycle control vector from the instruction's step list; a
// negedge monitor pops and compares it against the DUT outputs.
module tb_mc_control_fsm;

  localparam int MAXW = 4;
  localparam int W    = 22;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic       zero_flag;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;
  logic       illegal_op, mem_timeout;

  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  logic pend_ill = 1'b0;
  logic pend_tmo = 1'b0;

  mc_control_fsm #(.MEM_WAIT_MAX(MAXW)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero_flag(zero_flag),
    .mem_ready(mem_ready), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .pc_source(pc_source), .state(state),
    .illegal_op(illegal_op), .mem_timeout(mem_timeout)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not finish, got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s got=%0h required=%0h at %0t", nm, got, req, $time);
    end
  endtask

  // Control vector the spec assigns to a named step of an instruction.
  function automatic logic [W-1:0] model_out(input logic [3:0] st, input logic rdy,
                                             input logic tmo, input logic ip,
                                             input logic tp);
    logic pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa;
    logic [1:0] asb, aop, psrc;
    {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa} = '0;
    asb = 2'b00; aop = 2'b00; psrc = 2'b00;
    case (st)
      4'd0:  begin mr = 1; asb = 2'b01; pw = rdy; irw = rdy; end
      4'd1:  asb = 2'b11;
      4'd2:  begin asa = 1; asb = 2'b10; end
      4'd3:  begin mr = 1; iod = 1; end
      4'd4:  begin rw = 1; m2r = 1; end
      4'd5:  begin mw = !tmo; iod = 1; end
      4'd6:  begin asa = 1; aop = 2'b10; end
      4'd7:  begin rw = 1; rd = 1; end
      4'd8:  begin asa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; end
      4'd9:  begin pw = 1; psrc = 2'b10; end
      4'd10: begin asa = 1; asb = 2'b10; end
      4'd11: rw = 1;
      default: ;
    endcase
    return {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa, asb, aop, psrc, st, ip, tp};
  endfunction

  function automatic logic is_legal(input logic [5:0] op);
    return op == 6'b000000 || op == 6'b100011 || op == 6'b101011 ||
           op == 6'b000100 || op == 6'b000010 || op == 6'b001000;
  endfunction

  // One clock cycle of an instruction: drive inputs, queue expected outputs.
  task automatic step(input logic [3:0] st, input logic rdy, input logic tmo,
                      input logic ill_now);
    mem_ready = rdy;
    exp_q.push_back(model_out(st, rdy, tmo, pend_ill, pend_tmo));
    pend_ill = ill_now;
    pend_tmo = tmo;
    @(posedge clk);
    #1;
  endtask

  // A memory-wait state held for 'waits' idle cycles; aborts past the limit.
  task automatic mem_phase(input logic [3:0] st, input int waits, output logic aborted);
    int n;
    n = (waits > MAXW) ? MAXW : waits;
    for (int i = 0; i < n; i++) step(st, 1'b0, 1'b0, 1'b0);
    if (waits > MAXW) begin
      step(st, 1'b0, 1'b1, 1'b0);
      aborted = 1'b1;
    end else begin
      step(st, 1'b1, 1'b0, 1'b0);
      aborted = 1'b0;
    end
  endtask

  task automatic run_instr(input logic [5:0] op, input int fw, input int mw,
                           input logic zf);
    logic ab;
    opcode    = op;
    zero_flag = zf;
    mem_phase(4'd0, fw, ab);
    if (ab) return;
    step(4'd1, 1'($urandom_range(0, 1)), 1'b0, !is_legal(op));
    if (!is_legal(op)) return;
    case (op)
      6'b000000: begin
        step(4'd6, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        step(4'd7, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      end
      6'b100011: begin
        step(4'd2, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        mem_phase(4'd3, mw, ab);
        if (!ab) step(4'd4, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      end
      6'b101011: begin
        step(4'd2, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        mem_phase(4'd5, mw, ab);
      end
      6'b000100: step(4'd8, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      6'b000010: step(4'd9, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      default: begin
        step(4'd10, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        step(4'd11, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      end
    endcase
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    check("drain", exp_q.size(), 0);
  endtask

  // Monitor: compare the DUT control vector against the queued expectation.
  always @(negedge clk) begin
    logic [W-1:0] e, g;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, state, illegal_op, mem_timeout};
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL ctrl_vec got=%06h required=%06h state=%0d at %0t", g, e, state, $time);
      end
    end
  end

  logic [5:0] ops [0:5];

  initial begin
    logic ab;
    logic [5:0] op;
    ops[0] = 6'b000000; ops[1] = 6'b100011; ops[2] = 6'b101011;
    ops[3] = 6'b000100; ops[4] = 6'b000010; ops[5] = 6'b001000;
    rst_n = 1'b0; opcode = 6'd0; zero_flag = 1'b0; mem_ready = 1'b1;
    #3;
    check("rst_state", 32'(state), 0);
    check("rst_mem_read", 32'(mem_read), 0);
    check("rst_ir_write", 32'(ir_write), 0);
    check("rst_pc_write", 32'(pc_write), 0);
    check("rst_illegal", 32'(illegal_op), 0);
    check("rst_timeout", 32'(mem_timeout), 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed: R-type, lw with 3 waits, beq both ways, illegal, sw timeout.
    run_instr(6'b000000, 0, 0, 1'b0);
    run_instr(6'b100011, 0, 3, 1'b0);
    run_instr(6'b000100, 0, 0, 1'b1);
    run_instr(6'b000100, 0, 0, 1'b0);
    run_instr(6'b111111, 0, 0, 1'b0);
    run_instr(6'b101011, 0, 9, 1'b0);
    run_instr(6'b000010, MAXW, 0, 1'b0);
    run_instr(6'b001000, MAXW + 1, 0, 1'b0);
    run_instr(6'b100011, 1, MAXW + 2, 1'b0);
    run_instr(6'b101011, 2, MAXW, 1'b0);
    run_instr(6'b001000, 0, 0, 1'b1);

    // Random instruction mix with random wait lengths around the limit.
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 7) == 0) op = 6'($urandom_range(0, 63));
      else op = ops[$urandom_range(0, 5)];
      run_instr(op, (($urandom_range(0, 3) == 0) ? $urandom_range(0, MAXW + 2) : 0),
                $urandom_range(0, MAXW + 2), 1'($urandom_range(0, 1)));
    end
    drain();

    // Asynchronous reset in the middle of a store wait.
    opcode = 6'b101011;
    mem_phase(4'd0, 0, ab);
    step(4'd1, 1'b0, 1'b0, 1'b0);
    step(4'd2, 1'b0, 1'b0, 1'b0);
    mem_ready = 1'b0;
    #1;
    check("memwr_state", 32'(state), 5);
    check("memwr_write", 32'(mem_write), 1);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_mem_write", 32'(mem_write), 0);
    check("async_rst_state", 32'(state), 0);
    check("async_rst_mem_read", 32'(mem_read), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    pend_ill = 1'b0;
    pend_tmo = 1'b0;

    for (int n = 0; n < 40; n++)
      run_instr(ops[$urandom_range(0, 5)], $urandom_range(0, 2),
                $urandom_range(0, MAXW + 1), 1'($urandom_range(0, 1)));
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
